// File: rtl/out_port_display_if.sv
// Bus between the datapath out_port register and the seven-segment scanner.
// The master drives the port value and enable; the slave returns the display signals.
interface out_port_display_if #(
    parameter int unsigned NUM_DIGITS = 8
);
    logic [31:0]           out_port_data;
    logic                  enable;
    logic [6:0]            seg;
    logic                  dp;
    logic [NUM_DIGITS-1:0] an;
    logic                  frame_tick;
    logic [31:0]           shown_value;

    modport master (
        output out_port_data, enable,
        input  seg, dp, an, frame_tick, shown_value
    );

    modport slave (
        input  out_port_data, enable,
        output seg, dp, an, frame_tick, shown_value
    );
endinterface

// File: rtl/out_port_display.sv
// Time-multiplexed hex display of the datapath output port. A shadow copy of the
// input is taken only at frame boundaries so one scan never mixes two values.
module out_port_display #(
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter int unsigned NUM_DIGITS     = 8,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          BLANK_LEADING  = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    out_port_display_if.slave   bus
);
    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = SEG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                              : {NUM_DIGITS{1'b0}};

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [31:0]           shown_q, shown_d;
    logic                  tick_q, tick_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic                  step;
    logic                  frame_load;
    logic [3:0]            nib;
    logic                  blank;
    logic [NUM_DIGITS-1:0] upper_nz;
    logic [NUM_DIGITS-1:0] an_hot;

    // Active-high {g,f,e,d,c,b,a} hex glyphs.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    assign step       = (presc_q == PRESC_MAX);
    assign frame_load = step && (idx_q == IDX_MAX);
    assign an_hot     = NUM_DIGITS'(1) << idx_q;

    // upper_nz[d] is set when any nibble from d up to the top digit is nonzero.
    always_comb begin : blank_scan
        logic acc;
        acc      = 1'b0;
        upper_nz = '0;
        for (int d = int'(NUM_DIGITS) - 1; d >= 0; d--) begin
            acc         = acc | (|shown_q[4*d +: 4]);
            upper_nz[d] = acc;
        end
    end

    // Select the nibble and blanking state of the digit currently scanned.
    always_comb begin
        nib   = '0;
        blank = 1'b0;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            if (idx_q == IW'(d)) begin
                nib   = shown_q[4*d +: 4];
                blank = BLANK_LEADING && (d != 0) && !upper_nz[d];
            end
        end
    end

    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        shown_d = shown_q;
        tick_d  = 1'b0;
        seg_d   = SEG_OFF;
        dp_d    = DP_OFF;
        an_d    = AN_OFF;

        if (step) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
        end else begin
            presc_d = presc_q + PW'(1);
        end

        if (frame_load) begin
            shown_d = bus.out_port_data;
            tick_d  = 1'b1;
        end

        if (!blank) begin
            seg_d = SEG_ACTIVE_LOW ? ~hex7(nib) : hex7(nib);
            if (bus.enable) begin
                an_d = SEG_ACTIVE_LOW ? ~an_hot : an_hot;
            end
        end

        // Decimal point on digit 0 flags an input value not yet displayed.
        if ((idx_q == '0) && (bus.out_port_data != shown_q)) begin
            dp_d = ~DP_OFF;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            idx_q   <= '0;
            shown_q <= '0;
            tick_q  <= 1'b0;
            seg_q   <= SEG_OFF;
            dp_q    <= DP_OFF;
            an_q    <= AN_OFF;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            shown_q <= shown_d;
            tick_q  <= tick_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
        end
    end

    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.an          = an_q;
    assign bus.frame_tick  = tick_q;
    assign bus.shown_value = shown_q;
endmodule

// File: tb/tb_out_port_display.sv
// Scoreboarded bench for out_port_display: a cycle-count reference model predicts
// each registered output; a negedge monitor compares whatever the DUT presents.
module tb_out_port_display;
    localparam int unsigned R     = 4;
    localparam int unsigned N     = 8;
    localparam int unsigned FRAME = R * N;
    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct {
        int unsigned tag;
        logic [6:0]  seg;
        logic        dp;
        logic [7:0]  an;
        logic        tick;
        logic [31:0] shown;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    out_port_display_if #(.NUM_DIGITS(N)) bus ();

    out_port_display #(
        .REFRESH_DIV(R), .NUM_DIGITS(N), .SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    exp_t        q[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int unsigned k;
    logic [31:0] m_shown;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Present inputs for one cycle and predict the outputs after the next edge.
    task automatic drive(input logic [31:0] d, input logic en);
        exp_t        e;
        int unsigned idx;
        logic [3:0]  nib;
        logic        blank;
        bus.out_port_data = d;
        bus.enable        = en;
        idx   = (k / R) % N;
        nib   = 4'(m_shown >> (4 * idx));
        blank = (idx != 0) && ((m_shown >> (4 * idx)) == 32'd0);
        e.tag = cyc + 1;
        e.seg = blank ? 7'h7F : ~HEX[nib];
        e.an  = (en && !blank) ? ~(8'(1) << idx) : 8'hFF;
        e.dp  = (idx == 0 && d != m_shown) ? 1'b0 : 1'b1;
        if ((k + 1) % FRAME == 0) begin
            m_shown = d;
            e.tick  = 1'b1;
        end else begin
            e.tick  = 1'b0;
        end
        e.shown = m_shown;
        q.push_back(e);
        k++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_an"},    32'(bus.an), 32'hFF);
        chk({tag, "_seg"},   32'(bus.seg), 32'h7F);
        chk({tag, "_dp"},    32'(bus.dp), 32'h1);
        chk({tag, "_tick"},  32'(bus.frame_tick), 32'h0);
        chk({tag, "_shown"}, bus.shown_value, 32'h0);
    endtask

    // Asynchronous reset between edges, checked immediately and after being held.
    task automatic mid_reset(input string tag);
        @(negedge clk);
        #1;
        chk({tag, "_q_drained"}, 32'(q.size()), 32'd0);
        reset = 1'b0;
        #1;
        check_reset_outputs({tag, "_now"});
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs({tag, "_held"});
        reset   = 1'b1;
        k       = 0;
        m_shown = '0;
    endtask

    function automatic logic [31:0] rand_val();
        int unsigned z;
        logic [31:0] v;
        v = $urandom;
        z = $urandom_range(0, 8);
        return (z == 8) ? 32'd0 : (v >> (4 * z));
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].tag <= cyc) begin
            mon_e = q.pop_front();
            chk("seg",         32'(bus.seg), 32'(mon_e.seg));
            chk("an",          32'(bus.an), 32'(mon_e.an));
            chk("dp",          32'(bus.dp), 32'(mon_e.dp));
            chk("frame_tick",  32'(bus.frame_tick), 32'(mon_e.tick));
            chk("shown_value", bus.shown_value, mon_e.shown);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        en;
        reset             = 1'b0;
        bus.out_port_data = '0;
        bus.enable        = 1'b0;
        k                 = 0;
        m_shown           = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        reset = 1'b1;

        repeat (2 * FRAME) drive(32'h1234_5678, 1'b1);
        repeat (13) drive(32'h1234_5678, 1'b1);
        chk("pre_reset_shown", bus.shown_value, 32'h1234_5678);
        mid_reset("rst1");

        repeat (2 * FRAME) drive(32'h0000_00A0, 1'b1);
        repeat (2 * FRAME) drive(32'h0000_0000, 1'b1);

        repeat (FRAME) drive(32'h1111_1111, 1'b1);
        repeat (10) drive(32'h1111_1111, 1'b1);
        repeat (FRAME - 10) drive(32'h2222_2222, 1'b1);
        repeat (FRAME) drive(32'h2222_2222, 1'b1);

        d = rand_val();
        for (int i = 0; i < 3 * int'(FRAME); i++) begin
            if ($urandom_range(0, 7) == 0) d = rand_val();
            drive(d, 1'b0);
        end

        en = 1'b1;
        for (int i = 0; i < 20 * int'(FRAME); i++) begin
            if ($urandom_range(0, 7) == 0) d = rand_val();
            if ($urandom_range(0, 15) == 0) en = ~en;
            drive(d, en);
            if (i == 9 * int'(FRAME) + 17) mid_reset("rst2");
        end

        @(negedge clk);
        #1;
        chk("final_q_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
